// File: rtl/ps2_receiver_if.sv
// PS/2 receive-side bus bundle: the shared psclk/psdata lines and inhibit in,
// decoded byte and status strobes out.
interface ps2_receiver_if;
  logic       psclk;
  logic       psdata;
  logic       inhibit;
  logic [7:0] data;
  logic       dataValid;
  logic       parityErr;
  logic       frameErr;
  logic       busy;

  modport master (
    output psclk, psdata, inhibit,
    input  data, dataValid, parityErr, frameErr, busy
  );

  modport slave (
    input  psclk, psdata, inhibit,
    output data, dataValid, parityErr, frameErr, busy
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional mid-frame idle timeout enabled by defining PS2_RX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling psclk edge with psdata low)
// DATA   | shifting in the 8 data bits
// PARITY | capturing the parity bit
// STOP   | checking the stop bit and reporting the frame outcome
module ps2_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input logic          slowClk,
  input logic          reset,
  ps2_receiver_if.slave bus
);

  // The idle counter is 16 bits wide and must outlast a full bit period.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_tmo_range
    $error("ps2_receiver: TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

`ifdef PS2_RX_TIMEOUT_EN
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Synchronizers reset to the pulled-up idle level so reset never fakes an edge.
  always_ff @(posedge slowClk or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= bus.psclk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= bus.psdata;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge slowClk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_q <= TMO_LOAD;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    if (bus.inhibit) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_d = TMO_LOAD;
`endif
    end else if (fall) begin
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_d = TMO_LOAD;
`endif
      case (state_q)
        S_IDLE: begin
          if (!dat_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_sync_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!dat_sync_q) begin
            frm_err_d = 1'b1;
          end else if (^{shift_q, parity_q}) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            par_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    else if (state_q != S_IDLE) begin
      if (tmo_cnt_q == '0) begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        frm_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q - 16'd1;
      end
    end
`endif
  end

  assign bus.data      = data_q;
  assign bus.dataValid = valid_q;
  assign bus.parityErr = par_err_q;
  assign bus.frameErr  = frm_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: directed scenarios plus random frames,
// expected outcomes derived from the frame rules and queued for a pulse monitor.
module tb_ps2_receiver;
  localparam int TMO = 50;

  logic slowClk = 1'b0;
  logic reset;
  ps2_receiver_if bus ();

  ps2_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .slowClk (slowClk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 slowClk = ~slowClk;

  typedef struct {
    logic [2:0] flags;   // {dataValid, parityErr, frameErr}
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe cycle must match the oldest queued expectation.
  always @(negedge slowClk) begin
    if (reset !== 1'b1 && (bus.dataValid || bus.parityErr || bus.frameErr)) begin
      exp_t e;
      logic [2:0] got;
      got = {bus.dataValid, bus.parityErr, bus.frameErr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual flags=%b data=%h required none", got, bus.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e.flags || bus.data !== e.data || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL frame_result actual flags=%b data=%h busy=%b required flags=%b data=%h busy=0",
                   got, bus.data, bus.busy, e.flags, e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge slowClk);
  endtask

  task automatic send_bit(input logic b);
    bus.psdata = b;
    idle(4);
    bus.psclk = 1'b0;
    idle(8);
    bus.psclk = 1'b1;
    idle(4);
  endtask

  // Reference model: outcome from the stop bit and the weight of data+parity.
  task automatic expect_frame(input logic [7:0] d, input logic par, input logic stp);
    exp_t e;
    if (!stp) begin
      e.flags = 3'b001; e.data = model_data;
    end else if ((($countones(d) + int'(par)) % 2) == 1) begin
      model_data = d;
      e.flags = 3'b100; e.data = d;
    end else begin
      e.flags = 3'b010; e.data = model_data;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    expect_frame(d, par, stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    bus.psdata = 1'b1;
    idle(6);
  endtask

  task automatic check_after(input string name);
    check({name, "_data"}, {24'd0, bus.data}, {24'd0, model_data});
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int lat;
    reset       = 1'b1;
    bus.psclk   = 1'b1;
    bus.psdata  = 1'b1;
    bus.inhibit = 1'b0;
    idle(3);
    check("reset_outputs",
          {21'd0, bus.data, bus.dataValid, bus.parityErr, bus.frameErr},
          32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    idle(5);

    send_frame(8'h1C, 1'b0, 1'b1);
    check_after("good_1c");
    send_frame(8'hF0, 1'b0, 1'b1);
    check_after("parity_err");
    send_frame(8'hAA, 1'b1, 1'b0);
    check_after("stop_err");

    // Partial frame: start + 3 data bits, then the 4th bit edge is timed.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.psdata = 1'b0;
    idle(4);
`ifdef PS2_RX_TIMEOUT_EN
    begin
      exp_t e;
      e.flags = 3'b001; e.data = model_data;
      exp_q.push_back(e);
    end
    bus.psclk = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge slowClk);
      if (k == 8) begin bus.psclk = 1'b1; bus.psdata = 1'b1; end
      if (bus.frameErr) begin lat = k; break; end
    end
    // psclk low is seen 3 cycles later, then TMO idle cycles elapse.
    check("timeout_latency", lat, TMO + 3);
    idle(2);
    check("timeout_busy", {31'd0, bus.busy}, 32'd0);
`else
    bus.psclk = 1'b0;
    idle(8);
    bus.psclk = 1'b1;
    bus.psdata = 1'b1;
    idle(200);
    check("no_timeout_busy", {31'd0, bus.busy}, 32'd1);
    bus.inhibit = 1'b1;
    idle(2);
    bus.inhibit = 1'b0;
    idle(2);
    check("inhibit_recover_busy", {31'd0, bus.busy}, 32'd0);
`endif
    send_frame(8'h55, 1'b1, 1'b1);
    check_after("after_timeout_55");

    // Inhibit after 5 bits of 0xF0; the remaining bits are all 1 and must be ignored.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    check("pre_inhibit_busy", {31'd0, bus.busy}, 32'd1);
    bus.inhibit = 1'b1;
    idle(10);
    bus.inhibit = 1'b0;
    check("inhibit_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(6);
    check_after("inhibit_tail");
    send_frame(8'h1C, 1'b0, 1'b1);
    check_after("post_inhibit_1c");

    // Asynchronous reset after 3 bits of 0x1C.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    #2 reset = 1'b1;
    #1;
    model_data = 8'h00;
    check("midreset_outputs",
          {21'd0, bus.data, bus.dataValid, bus.parityErr, bus.frameErr},
          32'd0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(4);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_after("post_reset_1c");

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       par;
      logic       stp;
      int         r;
      d   = 8'($urandom_range(0, 255));
      r   = int'($urandom_range(0, 7));
      par = ~^d;
      if (r == 0) par = ~par;
      stp = (r == 1) ? 1'b0 : 1'b1;
      send_frame(d, par, stp);
      check_after("random");
    end

    idle(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Receives device-to-host PS/2 frames (keyboard scan codes) on the shared psclk/psdata lines, which are open-drain and externally pulled up. The block samples the bus in the slowClk domain, deserializes start, 8 data bits (LSB first), odd parity and stop, and presents each byte with a one-cycle valid strobe. It is the receive-direction counterpart to the host command sender. The sender's busy indication drives `inhibit` so that host-originated traffic is never decoded as device data.

## Interface
- `TIMEOUT_CYCLES`, default 2000: number of slowClk cycles without a psclk falling edge, while mid-frame, before the frame is aborted. Must exceed one PS/2 bit period expressed in slowClk cycles.
- `slowClk` input, 1: clock, rising-edge.
- `reset` input, 1: reset, asynchronous, active-high.
- `psclk` input, 1: PS/2 clock line (read-only here).
- `psdata` input, 1: PS/2 data line (read-only here).
- `inhibit` input, 1: high while the host sender owns the bus. Forces IDLE.
- `data` output, 8: last correctly received byte.
- `dataValid` output, 1: one-cycle pulse when `data` updates.
- `parityErr` output, 1: one-cycle pulse when a frame has bad parity.
- `frameErr` output, 1: one-cycle pulse on bad stop bit or timeout.
- `busy` output, 1: high whenever state is not IDLE.

## Operation
- **Synchronization:** `psclk` and `psdata` each pass through a 2-flop synchronizer. A third register holds the previous synchronized psclk. A falling edge is detected when prev=1 and sync=0. psdata is sampled from its synchronized value in the same cycle as the detected edge.
- **State machine:** IDLE, DATA, PARITY, STOP. A 3-bit bit counter and an 8-bit shift register support it.
  - IDLE, falling edge, data=0 → DATA, counter cleared. A falling edge with data=1 is ignored.
  - DATA, falling edge → shift the bit in at MSB, shifting right, so the byte is LSB-first. After the 8th bit → PARITY.
  - PARITY, falling edge → store the bit → STOP.
  - STOP, falling edge → IDLE. The outcome depends on the stop bit and parity:
    - Stop=1 and the 9 bits (data plus parity) have odd weight: `data` takes the shift register value and `dataValid` pulses.
    - Stop=1 and parity is even: `parityErr` pulses and `data` is unchanged.
    - Stop=0: `frameErr` pulses, regardless of parity, and `data` is unchanged.
- **Pulses:** at most one of `dataValid`, `parityErr` or `frameErr` pulses per frame.
- **inhibit high:** state → IDLE and counters clear, with no pulses. The frame aborts silently.
- **Reset values:** all outputs 0, `data`=0x00. State is IDLE and the synchronizers are loaded with 1, the idle bus level.

## Timing
- **Latency:** let E1 be the first slowClk rising edge that samples psclk low at the stop bit. The state update and output pulse take effect at E3, and the pulse is high from E3 to E4.
- **Pulse width:** each pulse is exactly one slowClk cycle.
- **busy:** rises at the edge where IDLE→DATA registers. It falls at the same edge as the result pulse.
- **Priority, highest first:** reset, then inhibit, then falling edge, then timeout. A falling edge in the same cycle as the timeout terminal count reloads the counter and the frame continues.
- **Reset mid-frame:** immediate IDLE with no pulse. The partial byte is discarded.

## Configuration
- `PS2_RX_TIMEOUT_EN`
  - **Defined:** a 16-bit idle counter runs while busy and clears on every detected falling edge. On reaching `TIMEOUT_CYCLES` it forces IDLE and pulses `frameErr` for one cycle.
  - **Undefined:** no counter exists. A partial frame waits indefinitely for further edges, and only reset or inhibit recover it.

## Test plan
- **Good frame:** send 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1). Expect `data`=0x1C, `dataValid` high for exactly 1 cycle, no error pulses, and `busy` low afterwards.
- **Parity error:** after 0x1C, send 0xF0 with parity 0 (correct is 1). Expect a single `parityErr` pulse, no `dataValid`, and `data` still 0x1C.
- **Stop-bit error:** send 0xAA with correct parity 1 and stop 0. Expect a `frameErr` pulse and `data` unchanged.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=50):** clock out the start bit plus 4 bits, then hold psclk high. Expect `frameErr` exactly 50 cycles after the last edge and `busy`=0. A following 0x55 frame must yield `data`=0x55.
- **Inhibit:** assert `inhibit` after 5 bits for 10 cycles, then finish clocking that frame's remaining bits. Expect no pulses. A subsequent full 0x1C frame must yield `dataValid`.
- **Reset mid-frame:** assert `reset` asynchronously after 3 bits. Expect all outputs 0 immediately and `busy`=0. The next 0x1C frame must decode correctly.
